mem_initiator: RTL and testbench
================================

# mem_initiator

Bus-side initiator for the coprocessor's memory unit: accepts word read/write requests over a valid/ready handshake and drives the memory strobe interface (`Read_sig`, `Write_sig`, `Mem_op_enable`, address, write data), capturing returned read data. It also issues single-cycle `Read_back_sig`/`Write_back_sig` pulses for memory image load and dump. It sits between the control unit and the memory unit.

## Interface
- `ADDR_WIDTH`, default `` `MEM_ADDR_WIDTH ``: memory address width.
- `WORD_WIDTH`, default `` `MEM_WORD_WIDTH `` (16): memory word width.
- `LEN_WIDTH`, default 4: burst length field; value n means n+1 words.
- `Global_clk` in 1: sole clock, rising edge.
- `Global_rst` in 1: asynchronous, active-high reset.
- `Req_valid` in 1: request present.
- `Req_ready` out 1: initiator can accept a request.
- `Req_write` in 1: 1 = single-word write, 0 = read burst.
- `Req_addr` in ADDR_WIDTH: start address.
- `Req_data` in WORD_WIDTH: write data.
- `Req_len` in LEN_WIDTH: read burst length minus 1; ignored for writes.
- `Resp_valid` out 1: one-cycle pulse per completed word.
- `Resp_data` out WORD_WIDTH: read word, or the written word for writes.
- `Resp_last` out 1: qualifies the final `Resp_valid` of a request.
- `Img_load_req`, `Img_dump_req` in 1: image load/dump requests, sampled in IDLE.
- `Read_back_sig`, `Write_back_sig` out 1: image strobes to memory.
- `Read_sig`, `Write_sig`, `Mem_op_enable` out 1: memory op controls.
- `Address_out` out ADDR_WIDTH; `Data_to_mem` out WORD_WIDTH; `Data_from_mem` in WORD_WIDTH.
- `Verify_err` out 1: sticky write-verify mismatch (macro only).

## Operation
- States: IDLE, SETUP, STROBE, CAPTURE, RESP, IMG, plus VSETUP, VSTROBE, VCAPTURE with the macro.
- Reset: all outputs 0 and state IDLE, except `Req_ready`=1 after reset deasserts.
- `Req_ready`=1 only in IDLE when no image request is sampled. Accept on `Req_valid & Req_ready` at a rising edge. Latch addr, data, write, and len.
- SETUP:
  - `Address_out`/`Data_to_mem` are driven.
  - Exactly one of `Read_sig`/`Write_sig` is high; both are never high together.
  - `Mem_op_enable`=0.
- STROBE: `Mem_op_enable`=1 for exactly one cycle. Address, data and op signals are held stable.
- CAPTURE: `Mem_op_enable`=0. Register `Data_from_mem` on reads.
- RESP:
  - `Resp_valid`=1 for one cycle; `Resp_last`=1 on the final word.
  - Read burst with words remaining: address increments modulo 2^ADDR_WIDTH (wrap from max to 0), then SETUP.
  - Otherwise go to IDLE; `Read_sig`/`Write_sig` drop to 0.
- There is no response backpressure; the consumer must take every pulse.
- Image requests in IDLE go to IMG:
  - The matching back-strobe is high for 1 cycle, then IDLE.
  - If both requests arrive in the same cycle, load wins and the dump is dropped.
  - An image request takes priority over a simultaneous `Req_valid`.
- Reset mid-operation:
  - Immediate return to IDLE with all strobes low.
  - Any burst is abandoned; no further `Resp_valid`.

## Timing
- Accept edge = cycle 0. SETUP cycle 1, STROBE cycle 2, CAPTURE cycle 3, RESP cycle 4.
- Each subsequent burst word adds 4 cycles. A (len+1)-word read completes with `Resp_last` at cycle 4(len+1).
- `Req_ready` returns high the cycle after the final RESP.
- Write without macro: `Resp_valid` at cycle 4.
- `Mem_op_enable` rises only after address, data and op signals have been stable one full cycle.

## Configuration
- `MEMI_WRITE_VERIFY_EN` defined:
  - After a write's CAPTURE, the block runs VSETUP/VSTROBE/VCAPTURE as a read of the same address.
  - It compares the result to the written data; a mismatch sets `Verify_err` (cleared only by reset).
  - RESP then follows, so write `Resp_valid` lands at cycle 7.
- Undefined: no verify states, writes complete at cycle 4, and `Verify_err` is tied to 0.

## Test plan
- Write 0xF00F to addr 0x0F, accepted at cycle 0:
  - `Write_sig`=1 from cycle 1.
  - `Mem_op_enable` pulse at cycle 2.
  - `Resp_valid`/`Resp_last`=1 at cycle 4 with data 0xF00F (cycle 7 with verify; `Verify_err`=0).
- Read burst with `Req_len`=2 from addr 0x0E, memory model holding 0x1111/0x2222/0x3333:
  - Three `Resp_valid` pulses at cycles 4/8/12 with those words.
  - `Resp_last` only at cycle 12.
- Read burst with `Req_len`=1 at max address: second access uses address 0; `Resp_valid` at cycles 4 and 8.
- `Img_load_req` and `Img_dump_req` together in IDLE:
  - `Read_back_sig` high exactly 1 cycle; `Write_back_sig` stays 0.
  - `Req_ready`=0 during IMG.
- Assert `Global_rst` during the STROBE cycle of a 4-word read:
  - `Mem_op_enable`, `Read_sig` and `Resp_valid` go to 0 immediately.
  - `Req_ready`=1 after reset release; no further responses.
- Verify build with a faulty memory model returning 0x0000: write 0xABCD -> `Verify_err`=1 at cycle 6 and it stays set.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready word initiator driving memory strobes and image pulses.
// Define MEMI_WRITE_VERIFY_EN to add a readback check after every write.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef MEM_WORD_WIDTH
`define MEM_WORD_WIDTH 16
`endif

module mem_initiator #(
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int WORD_WIDTH = `MEM_WORD_WIDTH,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  Global_clk,
  input  logic                  Global_rst,
  input  logic                  Req_valid,
  output logic                  Req_ready,
  input  logic                  Req_write,
  input  logic [ADDR_WIDTH-1:0] Req_addr,
  input  logic [WORD_WIDTH-1:0] Req_data,
  input  logic [LEN_WIDTH-1:0]  Req_len,
  output logic                  Resp_valid,
  output logic [WORD_WIDTH-1:0] Resp_data,
  output logic                  Resp_last,
  input  logic                  Img_load_req,
  input  logic                  Img_dump_req,
  output logic                  Read_back_sig,
  output logic                  Write_back_sig,
  output logic                  Read_sig,
  output logic                  Write_sig,
  output logic                  Mem_op_enable,
  output logic [ADDR_WIDTH-1:0] Address_out,
  output logic [WORD_WIDTH-1:0] Data_to_mem,
  input  logic [WORD_WIDTH-1:0] Data_from_mem,
  output logic                  Verify_err
);

  typedef enum logic [3:0] {
    IDLE, SETUP, STROBE, CAPTURE, RESP, IMG,
    VSETUP, VSTROBE, VCAPTURE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  wr_q;
  logic                  load_q;
  logic                  img_req;
  logic                  last;
  logic                  op;
  logic                  vphase;

  assign img_req = Img_load_req | Img_dump_req;
  assign last    = wr_q | (len_q == '0);

  always_ff @(posedge Global_clk or posedge Global_rst) begin
    if (Global_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (img_req)        state_d = IMG;
        else if (Req_valid) state_d = SETUP;
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = CAPTURE;
`ifdef MEMI_WRITE_VERIFY_EN
      CAPTURE:  state_d = wr_q ? VSETUP : RESP;
      VSETUP:   state_d = VSTROBE;
      VSTROBE:  state_d = VCAPTURE;
      VCAPTURE: state_d = RESP;
`else
      CAPTURE:  state_d = RESP;
`endif
      RESP:    state_d = last ? IDLE : SETUP;
      IMG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Global_clk or posedge Global_rst) begin
    if (Global_rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (img_req) begin
          load_q <= Img_load_req;
        end else if (Req_valid) begin
          addr_q <= Req_addr;
          data_q <= Req_data;
          len_q  <= Req_len;
          wr_q   <= Req_write;
        end
      end
      if (state_q == CAPTURE && !wr_q) rdata_q <= Data_from_mem;
      // Burst advance: address wraps naturally at the top of the space
      if (state_q == RESP && !last) begin
        addr_q <= addr_q + 1'b1;
        len_q  <= len_q - 1'b1;
      end
    end
  end

`ifdef MEMI_WRITE_VERIFY_EN
  logic verr_q;
  logic vmiss;

  assign vmiss = (state_q == VCAPTURE) && (Data_from_mem != data_q);

  always_ff @(posedge Global_clk or posedge Global_rst) begin
    if (Global_rst) verr_q <= 1'b0;
    else if (vmiss) verr_q <= 1'b1;
  end

  assign Verify_err = verr_q | vmiss;
`else
  assign Verify_err = 1'b0;
`endif

  assign vphase = state_q inside {VSETUP, VSTROBE, VCAPTURE};
  assign op     = vphase | (state_q inside {SETUP, STROBE, CAPTURE, RESP});

  always_comb begin
    Req_ready      = 1'b0;
    Resp_valid     = 1'b0;
    Resp_last      = 1'b0;
    Resp_data      = '0;
    Read_back_sig  = 1'b0;
    Write_back_sig = 1'b0;
    Read_sig       = 1'b0;
    Write_sig      = 1'b0;
    Mem_op_enable  = 1'b0;
    Address_out    = '0;
    Data_to_mem    = '0;
    if (op) begin
      Read_sig    = ~wr_q | vphase;
      Write_sig   = wr_q & ~vphase;
      Address_out = addr_q;
      Data_to_mem = data_q;
    end
    unique case (state_q)
      IDLE:    Req_ready = ~img_req & ~Global_rst;
      STROBE:  Mem_op_enable = 1'b1;
      VSTROBE: Mem_op_enable = 1'b1;
      RESP: begin
        Resp_valid = 1'b1;
        Resp_last  = last;
        Resp_data  = wr_q ? data_q : rdata_q;
      end
      IMG: begin
        Read_back_sig  = load_q;
        Write_back_sig = ~load_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed stimulus with a response scoreboard.
// Build with MEMI_WRITE_VERIFY_EN to exercise the readback path.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef MEM_WORD_WIDTH
`define MEM_WORD_WIDTH 16
`endif

module tb_mem_initiator;
  localparam int AW = `MEM_ADDR_WIDTH;
  localparam int WW = `MEM_WORD_WIDTH;
  localparam int LW = 4;
`ifdef MEMI_WRITE_VERIFY_EN
  localparam int WCYC = 7;
`else
  localparam int WCYC = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Req_valid = 0, Req_write = 0;
  logic [AW-1:0] Req_addr = '0;
  logic [WW-1:0] Req_data = '0;
  logic [LW-1:0] Req_len = '0;
  logic          Img_load_req = 0, Img_dump_req = 0;
  logic          Req_ready, Resp_valid, Resp_last;
  logic [WW-1:0] Resp_data, Data_to_mem, Data_from_mem;
  logic          Read_back_sig, Write_back_sig;
  logic          Read_sig, Write_sig, Mem_op_enable, Verify_err;
  logic [AW-1:0] Address_out;

  mem_initiator #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LEN_WIDTH(LW)) dut (
    .Global_clk(clk), .Global_rst(rst),
    .Req_valid(Req_valid), .Req_ready(Req_ready),
    .Req_write(Req_write), .Req_addr(Req_addr),
    .Req_data(Req_data), .Req_len(Req_len),
    .Resp_valid(Resp_valid), .Resp_data(Resp_data),
    .Resp_last(Resp_last),
    .Img_load_req(Img_load_req), .Img_dump_req(Img_dump_req),
    .Read_back_sig(Read_back_sig), .Write_back_sig(Write_back_sig),
    .Read_sig(Read_sig), .Write_sig(Write_sig),
    .Mem_op_enable(Mem_op_enable), .Address_out(Address_out),
    .Data_to_mem(Data_to_mem), .Data_from_mem(Data_from_mem),
    .Verify_err(Verify_err)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 0;
  logic [AW-1:0] pl_addr = '0;
  logic [WW-1:0] pl_data = '0;
  logic          faulty = 0;
  int            cnt = 0;

  always @(posedge clk) begin
    cnt <= cnt + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (Mem_op_enable && Write_sig) mem[Address_out] <= Data_to_mem;
  end

  assign Data_from_mem = (!Read_sig || faulty) ? '0 : mem[Address_out];

  typedef struct packed {
    int          cyc;
    logic [WW-1:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  int acc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && Resp_valid) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_resp: got %0h want none", Resp_data);
      end else begin
        e = q.pop_front();
        chk("resp_data", 32'(Resp_data), 32'(e.data));
        chk("resp_last", 32'(Resp_last), 32'(e.last));
        chk("resp_cycle", 32'(cnt - acc + 1), 32'(e.cyc));
      end
    end
    if (Read_sig || Write_sig)
      chk("op_excl", 32'(Read_sig & Write_sig), 32'd0);
  end

  task automatic poke(logic [AW-1:0] a, logic [WW-1:0] d);
    @(negedge clk);
    pl_en = 1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic issue(logic wr, logic [AW-1:0] a,
                       logic [WW-1:0] d, logic [LW-1:0] len);
    int n = 0;
    @(negedge clk);
    Req_valid = 1; Req_write = wr; Req_addr = a;
    Req_data = d; Req_len = len;
    while (!Req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!Req_ready) begin
      vecs++;
      errs++;
      $display("FAIL accept_timeout: got ready 0 want 1");
    end
    @(posedge clk); #1;
    acc = cnt;
    Req_valid = 0;
  endtask

  task automatic at(int c);
    do @(negedge clk); while (cnt - acc + 1 < c);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Req_ready && n < 80);
    chk("idle_reached", 32'(Req_ready), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(Req_ready), 32'd0);
    chk("rst_memen", 32'(Mem_op_enable), 32'd0);
    chk("rst_rdsig", 32'(Read_sig | Write_sig), 32'd0);
    rst = 0;
    #1 chk("post_rst_ready", 32'(Req_ready), 32'd1);

    issue(1'b1, 8'h0F, 16'hF00F, 4'd0);
    q.push_back('{WCYC, 16'hF00F, 1'b1});
    at(1);
    chk("w_wrsig", 32'(Write_sig), 32'd1);
    chk("w_memen_c1", 32'(Mem_op_enable), 32'd0);
    chk("w_addr", 32'(Address_out), 32'h0F);
    chk("w_data", 32'(Data_to_mem), 32'hF00F);
    at(2);
    chk("w_memen_c2", 32'(Mem_op_enable), 32'd1);
    at(3);
    chk("w_memen_c3", 32'(Mem_op_enable), 32'd0);
    at(WCYC);
    chk("w_ready_resp", 32'(Req_ready), 32'd0);
    at(WCYC + 1);
    chk("w_ready_after", 32'(Req_ready), 32'd1);
    chk("w_wrsig_drop", 32'(Write_sig), 32'd0);
    chk("w_verr", 32'(Verify_err), 32'd0);
    wait_idle();

    poke(8'h0E, 16'h1111);
    poke(8'h0F, 16'h2222);
    poke(8'h10, 16'h3333);
    issue(1'b0, 8'h0E, 16'h0000, 4'd2);
    q.push_back('{4, 16'h1111, 1'b0});
    q.push_back('{8, 16'h2222, 1'b0});
    q.push_back('{12, 16'h3333, 1'b1});
    at(2);
    chk("r_rdsig", 32'(Read_sig), 32'd1);
    chk("r_memen", 32'(Mem_op_enable), 32'd1);
    at(6);
    chk("r_addr2", 32'(Address_out), 32'h0F);
    wait_idle();

    poke(8'hFF, 16'hAAAA);
    poke(8'h00, 16'h5555);
    issue(1'b0, 8'hFF, 16'h0000, 4'd1);
    q.push_back('{4, 16'hAAAA, 1'b0});
    q.push_back('{8, 16'h5555, 1'b1});
    at(5);
    chk("wrap_addr", 32'(Address_out), 32'h00);
    wait_idle();

    @(negedge clk);
    Img_load_req = 1; Img_dump_req = 1;
    #1 chk("img_ready_idle", 32'(Req_ready), 32'd0);
    @(posedge clk); #1;
    Img_load_req = 0; Img_dump_req = 0;
    @(negedge clk);
    chk("img_rdback", 32'(Read_back_sig), 32'd1);
    chk("img_wrback", 32'(Write_back_sig), 32'd0);
    chk("img_ready", 32'(Req_ready), 32'd0);
    @(negedge clk);
    chk("img_rdback_end", 32'(Read_back_sig), 32'd0);
    chk("img_ready_end", 32'(Req_ready), 32'd1);

    @(negedge clk);
    Img_dump_req = 1; Req_valid = 1; Req_write = 0;
    Req_addr = 8'h40; Req_len = 4'd0;
    @(posedge clk); #1;
    Img_dump_req = 0; Req_valid = 0;
    @(negedge clk);
    chk("dump_wrback", 32'(Write_back_sig), 32'd1);
    chk("dump_rdback", 32'(Read_back_sig), 32'd0);
    chk("dump_no_read", 32'(Read_sig), 32'd0);
    repeat (8) @(negedge clk);

    issue(1'b0, 8'h20, 16'h0000, 4'd3);
    at(2);
    chk("rst_mid_memen_pre", 32'(Mem_op_enable), 32'd1);
    #2 rst = 1;
    #1;
    chk("rst_mid_memen", 32'(Mem_op_enable), 32'd0);
    chk("rst_mid_rdsig", 32'(Read_sig), 32'd0);
    chk("rst_mid_resp", 32'(Resp_valid), 32'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("rst_mid_ready", 32'(Req_ready), 32'd1);
    repeat (20) @(negedge clk);

`ifdef MEMI_WRITE_VERIFY_EN
    faulty = 1;
    issue(1'b1, 8'h30, 16'hABCD, 4'd0);
    q.push_back('{7, 16'hABCD, 1'b1});
    at(5);
    chk("verr_c5", 32'(Verify_err), 32'd0);
    at(6);
    chk("verr_c6", 32'(Verify_err), 32'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("verr_sticky", 32'(Verify_err), 32'd1);
    faulty = 0;
`endif

    chk("final_queue", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
